alu_seq_ctrl: RTL and testbench

//  Sequences one ALU operation per accepted request: read two RF operands, drive ALU, write back, update PSR.

---
 rtl/alu_req_if.sv | 20 ++
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_if.sv
// Decoder-to-sequencer request handshake (valid/ready plus operation fields).
// The compare-only field is present when ALU_CMP_EN is defined.
interface alu_req_if #(
    parameter int ADDR_W = 4
);
    logic              valid;
    logic              ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src;
`ifdef ALU_CMP_EN
    logic              cmp;

    modport master (output valid, op, dst, src, cmp, input ready);
    modport slave  (input valid, op, dst, src, cmp, output ready);
`else
    modport master (output valid, op, dst, src, input ready);
    modport slave  (input valid, op, dst, src, output ready);
`endif
endinterface

// File: rtl/alu_seq_ctrl.sv
// Non-pipelined ALU sequencer: IDLE -> FETCH -> EXEC -> WB, owns the {C,L,F,Z,N} PSR.
// Optional ALU_CMP_EN adds compare-only requests (forced sub, no writeback, full PSR update).
module alu_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_req_if.slave          req,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [WIDTH-1:0]  rf_rd_data_a,
    input  logic [WIDTH-1:0]  rf_rd_data_b,
    output logic [WIDTH-1:0]  alu_dst,
    output logic [WIDTH-1:0]  alu_src,
    output logic [2:0]        alu_op,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [4:0]        alu_flags,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [WIDTH-1:0]  rf_wr_data,
    output logic [4:0]        psr,
    output logic              done,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q, src_q;
    logic              cmp_q;
    logic [WIDTH-1:0]  opa_q, opb_q, res_q;
    logic [4:0]        psr_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req.valid) state_nxt = FETCH;
            FETCH:   state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    // Compare is latched as a sub, so it falls into the arithmetic (all-flags) class.
    always_comb begin
        if (op_q[1:0] == 2'b00)  psr_mask = 5'b11111;
        else if (op_q == 3'b111) psr_mask = 5'b00010;
        else                     psr_mask = 5'b00011;
    end

`ifdef ALU_CMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         cmp_q <= 1'b0;
        else if (state == IDLE && req.valid) cmp_q <= req.cmp;
    end
`else
    assign cmp_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            dst_q <= '0;
            src_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            psr   <= '0;
        end else begin
            if (state == IDLE && req.valid) begin
`ifdef ALU_CMP_EN
                op_q <= req.cmp ? 3'b100 : req.op;
`else
                op_q <= req.op;
`endif
                dst_q <= req.dst;
                src_q <= req.src;
            end
            // RF read data arrives during EXEC; capture operands, result and flags at EXEC->WB.
            if (state == EXEC) begin
                opa_q <= rf_rd_data_a;
                opb_q <= rf_rd_data_b;
                res_q <= alu_result;
                psr   <= (psr & ~psr_mask) | (alu_flags & psr_mask);
            end
        end
    end

    always_comb begin
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        alu_dst      = opa_q;
        alu_src      = opb_q;
        alu_op       = '0;
        rf_we        = 1'b0;
        rf_wr_addr   = '0;
        rf_wr_data   = '0;
        done         = 1'b0;
        case (state)
            FETCH: begin
                rf_rd_addr_a = dst_q;
                rf_rd_addr_b = src_q;
                alu_op       = op_q;
            end
            EXEC: begin
                rf_rd_addr_a = dst_q;
                rf_rd_addr_b = src_q;
                alu_dst      = rf_rd_data_a;
                alu_src      = rf_rd_data_b;
                alu_op       = op_q;
            end
            WB: begin
                alu_op     = op_q;
                rf_we      = ~cmp_q;
                rf_wr_addr = dst_q;
                rf_wr_data = res_q;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign req.ready = (state == IDLE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: RF and ALU models around the DUT, directed spec cases plus random ops
// checked against an array-level reference of registers and PSR. Define ALU_CMP_EN for compare cases.
module tb_alu_seq_ctrl;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_req_if #(.ADDR_W(ADDR_W)) req ();

    logic [ADDR_W-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
    logic [WIDTH-1:0]  rf_rd_data_a, rf_rd_data_b, alu_dst, alu_src, alu_result, rf_wr_data;
    logic [2:0]        alu_op;
    logic [4:0]        alu_flags, psr;
    logic              rf_we, done, busy;

    alu_seq_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .alu_dst(alu_dst), .alu_src(alu_src), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .psr(psr), .done(done), .busy(busy)
    );

    // ALU behaviour: returns {C,L,F,Z,N, result}
    function automatic logic [20:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic        c, f;
        c = 1'b0; f = 1'b0; r = '0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                          f = (a[15] == b[15]) && (r[15] != a[15]); end
            3'b100: begin r = a - b; c = (a < b); f = (a[15] != b[15]) && (r[15] != a[15]); end
            3'b111: begin p = a * b; r = p[15:0]; end
            default: case (op[1:0])
                2'b01:   r = a & b;
                2'b10:   r = a | b;
                default: r = a ^ b;
            endcase
        endcase
        return {c, (a < b), f, (r == 16'h0), r[15], r};
    endfunction

    // Register file (synchronous read) and combinational ALU
    logic [WIDTH-1:0] rf [16];
    int we_cnt = 0;
    always @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        if (rf_we) begin
            rf[rf_wr_addr] <= rf_wr_data;
            we_cnt <= we_cnt + 1;
        end
    end
    always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_dst, alu_src);

    // Reference state
    logic [15:0] ref_rf [16];
    logic [4:0]  ref_psr;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input int a, input logic [15:0] v);
        rf[a]     = v;
        ref_rf[a] = v;
    endtask

    task automatic ref_apply(input logic [2:0] op, input int dst, input int src, input logic cmp);
        logic [20:0] o;
        logic [4:0]  m;
        logic [2:0]  eop;
        eop = cmp ? 3'b100 : op;
        o   = alu_fn(eop, ref_rf[dst], ref_rf[src]);
        if (eop == 3'b000 || eop == 3'b100) m = 5'b11111;
        else if (eop == 3'b111)             m = 5'b00010;
        else                                m = 5'b00011;
        ref_psr = (ref_psr & ~m) | (o[20:16] & m);
        if (!cmp) ref_rf[dst] = o[15:0];
    endtask

    task automatic drive(input logic [2:0] op, input int dst, input int src, input logic cmp);
        req.valid = 1'b1;
        req.op    = op;
        req.dst   = ADDR_W'(dst);
        req.src   = ADDR_W'(src);
`ifdef ALU_CMP_EN
        req.cmp   = cmp;
`else
        if (cmp) $display("note: compare request ignored in this build");
`endif
    endtask

    // Called one cycle after the accept edge; returns one cycle after the WB edge.
    task automatic finish_op(input logic [2:0] op, input int dst, input int src, input logic cmp);
        int n;
        n = 1;
        while (!done && n < 10) begin
            chk("ready_low_busy", 32'(req.ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("alu_op_wb", 32'(alu_op), cmp ? 32'd4 : 32'(op));
        ref_apply(op, dst, src, cmp);
        chk("psr", 32'(psr), 32'(ref_psr));
        chk("rf_we", 32'(rf_we), 32'(!cmp));
        if (!cmp) chk("wr_data", 32'(rf_wr_data), 32'(ref_rf[dst]));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_back", 32'(req.ready), 32'd1);
        chk("rf_dst", 32'(rf[dst]), 32'(ref_rf[dst]));
    endtask

    task automatic issue(input logic [2:0] op, input int dst, input int src, input logic cmp);
        int n;
        drive(op, dst, src, cmp);
        n = 0;
        while (!req.ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req.valid = 1'b0;
        chk("accepted", 32'(busy), 32'd1);
        finish_op(op, dst, src, cmp);
    endtask

    initial begin
        int w0;
        logic [2:0] rop;
        int rd, rs;
        req.valid = 1'b0; req.op = '0; req.dst = '0; req.src = '0;
`ifdef ALU_CMP_EN
        req.cmp = 1'b0;
`endif
        for (int i = 0; i < 16; i++) set_reg(i, 16'(i * 16'h0111));
        ref_psr = '0;
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(req.ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_we",    32'(rf_we), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_psr",   32'(psr), 32'd0);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        @(posedge clk); #1; @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 0x7FFF + 1 overflow
        set_reg(1, 16'h7FFF); set_reg(2, 16'h0001);
        issue(3'b000, 1, 2, 1'b0);
        chk("add_res", 32'(rf[1]), 32'h8000);
        chk("add_psr", 32'(psr), 32'b00101);

        // 5 - 5, then xor self
        set_reg(3, 16'h0005); set_reg(4, 16'h0005);
        issue(3'b100, 3, 4, 1'b0);
        chk("sub_res", 32'(rf[3]), 32'h0);
        chk("sub_psr", 32'(psr), 32'b00010);
        set_reg(5, 16'h1234);
        issue(3'b011, 5, 5, 1'b0);
        chk("xor_psr", 32'(psr), 32'b00010);

        // mul truncation keeps F,N from a preceding overflow add
        set_reg(1, 16'h7FFF);
        issue(3'b000, 1, 2, 1'b0);
        set_reg(6, 16'h0100); set_reg(7, 16'h0100);
        issue(3'b111, 6, 7, 1'b0);
        chk("mul_res", 32'(rf[6]), 32'h0);
        chk("mul_psr", 32'(psr), 32'b00111);

        // back-to-back: second request held valid through the busy window
        set_reg(8, 16'h00F0); set_reg(9, 16'h0F0F);
        drive(3'b010, 8, 9, 1'b0);
        @(posedge clk); #1;
        chk("b2b_acc1", 32'(busy), 32'd1);
        drive(3'b001, 9, 8, 1'b0);
        finish_op(3'b010, 8, 9, 1'b0);
        @(posedge clk); #1;
        chk("b2b_acc2_cycle4", 32'(busy), 32'd1);
        req.valid = 1'b0;
        finish_op(3'b001, 9, 8, 1'b0);

`ifdef ALU_CMP_EN
        set_reg(1, 16'h0003); set_reg(2, 16'h0009);
        w0 = we_cnt;
        issue(3'b000, 1, 2, 1'b1);
        chk("cmp_no_we", 32'(we_cnt), 32'(w0));
        chk("cmp_r1", 32'(rf[1]), 32'h0003);
        chk("cmp_L", 32'(psr[3]), 32'd1);
        chk("cmp_N", 32'(psr[0]), 32'd1);
        chk("cmp_Z", 32'(psr[1]), 32'd0);
`endif

        // random operations
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) for (int i = 0; i < 16; i++) set_reg(i, 16'($urandom));
            rop = 3'($urandom);
            rd  = int'($urandom_range(0, 15));
            rs  = int'($urandom_range(0, 15));
`ifdef ALU_CMP_EN
            issue(rop, rd, rs, 1'($urandom_range(0, 3) == 0));
`else
            issue(rop, rd, rs, 1'b0);
`endif
        end
        for (int i = 0; i < 16; i++) chk("rf_final", 32'(rf[i]), 32'(ref_rf[i]));

        // reset during EXEC abandons the op
        set_reg(10, 16'h1111); set_reg(11, 16'h2222);
        w0 = we_cnt;
        drive(3'b000, 10, 11, 1'b0);
        @(posedge clk); #1;
        req.valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        ref_psr = '0;
        chk("mid_rst_ready", 32'(req.ready), 32'd1);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_psr",   32'(psr), 32'd0);
        chk("mid_rst_we",    32'(rf_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("mid_rst_no_wr", 32'(we_cnt), 32'(w0));
        chk("mid_rst_r10",   32'(rf[10]), 32'h1111);
        chk("mid_rst_idle",  32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
